// File: rtl/ws_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ws_inst_sequencer
//  Description : Generates the 34-bit core instruction stream for one
//                weight-stationary tile (weights, load, acts, exec, writeback).
//  Revision    : 1.0  initial release
// ============================================================================
module ws_inst_sequencer #(
   parameter int unsigned ROW      = 8,
   parameter int unsigned COL      = 8,
   parameter int unsigned LEN_NIJ  = 36,
   parameter int unsigned LOAD_GAP = 8,
   parameter int unsigned ADDR_W   = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] p_base,
   input  logic [4:0]        l0_ofifo_valid,
   output logic [33:0]       inst,
   output logic              busy,
   output logic              done
);

   localparam logic [33:0] c_IDLE_INST = 34'h1_800C_0000;

   localparam int c_B_CEN_PMEM = 32;
   localparam int c_B_WEN_PMEM = 31;
   localparam int c_B_CEN_XMEM = 19;
   localparam int c_B_OFIFO_RD = 6;
   localparam int c_B_L0_RD    = 3;
   localparam int c_B_L0_WR    = 2;
   localparam int c_B_EXECUTE  = 1;
   localparam int c_B_LOAD     = 0;

   localparam int unsigned c_RD_MAX = (ROW > LEN_NIJ) ? ROW : LEN_NIJ;
   localparam int unsigned c_PH_M1  = (COL > LOAD_GAP) ? COL : LOAD_GAP;
   localparam int unsigned c_PH_MAX = (c_PH_M1 > LEN_NIJ) ? c_PH_M1 : LEN_NIJ;
   localparam int c_RD_W = $clog2(c_RD_MAX + 1);
   localparam int c_PH_W = $clog2(c_PH_MAX + 1);
   localparam int c_WB_W = $clog2(LEN_NIJ + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_W_RD   = 3'd1,
      S_W_LOAD = 3'd2,
      S_W_GAP  = 3'd3,
      S_A_RD   = 3'd4,
      S_EXEC   = 3'd5,
      S_WB     = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t              r_state;
   logic [c_RD_W-1:0]   r_rd_cnt;
   logic [c_PH_W-1:0]   r_ph_cnt;
   logic [c_WB_W-1:0]   r_wb_cnt;
   logic                r_rd_pend;
   logic [ADDR_W-1:0]   r_w_base;
   logic [ADDR_W-1:0]   r_a_base;
   logic [ADDR_W-1:0]   r_p_base;
   logic [33:0]         r_inst;
   logic                r_busy;
   logic                r_done;

   logic                w_l0_full;
   logic                w_ofifo_valid;
   logic [ADDR_W-1:0]   w_rd_base;
   logic [ADDR_W-1:0]   w_xmem_addr;
   logic [ADDR_W-1:0]   w_pmem_addr;
   logic [c_RD_W-1:0]   w_rd_target;
   logic                w_unused_status;

   assign w_l0_full       = l0_ofifo_valid[1];
   assign w_ofifo_valid   = l0_ofifo_valid[4];
   assign w_unused_status = ^{l0_ofifo_valid[3:2], l0_ofifo_valid[0]};

   assign w_rd_base   = (r_state == S_A_RD) ? r_a_base : r_w_base;
   assign w_rd_target = (r_state == S_A_RD) ? c_RD_W'(LEN_NIJ) : c_RD_W'(ROW);
   assign w_xmem_addr = w_rd_base + ADDR_W'(r_rd_cnt);
   assign w_pmem_addr = r_p_base + ADDR_W'(r_wb_cnt);

   // Each edge rebuilds inst from the idle word; states only override the
   // fields they drive, so any cycle without an access is idle by default.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_rd_cnt  <= '0;
         r_ph_cnt  <= '0;
         r_wb_cnt  <= '0;
         r_rd_pend <= 1'b0;
         r_w_base  <= '0;
         r_a_base  <= '0;
         r_p_base  <= '0;
         r_inst    <= c_IDLE_INST;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_inst    <= c_IDLE_INST;
         r_done    <= 1'b0;
         r_rd_pend <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_w_base <= w_base;
                  r_a_base <= a_base;
                  r_p_base <= p_base;
                  r_rd_cnt <= '0;
                  r_ph_cnt <= '0;
                  r_wb_cnt <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_W_RD;
               end
            end

            // SRAM data lands one cycle after the read, so l0_wr trails the
            // read strobe; the edge that sees the final count emits the tail.
            S_W_RD, S_A_RD: begin
               r_inst[c_B_L0_WR] <= r_rd_pend;
               if (r_rd_cnt == w_rd_target) begin
                  r_rd_cnt <= '0;
                  if (r_state == S_W_RD) begin
                     r_state <= S_W_LOAD;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end else if (!w_l0_full) begin
                  r_inst[c_B_CEN_XMEM] <= 1'b0;
                  r_inst[17:7]         <= 11'(w_xmem_addr);
                  r_rd_cnt             <= r_rd_cnt + 1'b1;
                  r_rd_pend            <= 1'b1;
               end
            end

            S_W_LOAD: begin
               r_inst[c_B_L0_RD] <= 1'b1;
               r_inst[c_B_LOAD]  <= 1'b1;
               if (r_ph_cnt == c_PH_W'(COL - 1)) begin
                  r_ph_cnt <= '0;
                  r_state  <= S_W_GAP;
               end else begin
                  r_ph_cnt <= r_ph_cnt + 1'b1;
               end
            end

            S_W_GAP: begin
               if (r_ph_cnt == c_PH_W'(LOAD_GAP - 1)) begin
                  r_ph_cnt <= '0;
                  r_state  <= S_A_RD;
               end else begin
                  r_ph_cnt <= r_ph_cnt + 1'b1;
               end
            end

            S_EXEC: begin
               r_inst[c_B_L0_RD]   <= 1'b1;
               r_inst[c_B_EXECUTE] <= 1'b1;
               if (r_ph_cnt == c_PH_W'(LEN_NIJ - 1)) begin
                  r_ph_cnt <= '0;
                  r_state  <= S_WB;
               end else begin
                  r_ph_cnt <= r_ph_cnt + 1'b1;
               end
            end

            // FIFO head is popped and written to PMEM in the same cycle.
            S_WB: begin
               if (w_ofifo_valid) begin
                  r_inst[c_B_OFIFO_RD] <= 1'b1;
                  r_inst[c_B_CEN_PMEM] <= 1'b0;
                  r_inst[c_B_WEN_PMEM] <= 1'b0;
                  r_inst[30:20]        <= 11'(w_pmem_addr);
                  r_wb_cnt             <= r_wb_cnt + 1'b1;
                  if (r_wb_cnt == c_WB_W'(LEN_NIJ - 1)) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign inst = r_inst;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ws_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws_inst_sequencer
//  Description : Directed self-checking bench for ws_inst_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ws_inst_sequencer;

   localparam logic [33:0] c_IDLE  = 34'h1_800C_0000;
   localparam logic [33:0] c_L0_WR = 34'h4;
   localparam logic [33:0] c_L0_RD = 34'h8;
   localparam logic [33:0] c_EXE   = 34'h2;
   localparam logic [33:0] c_LOAD  = 34'h1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] w_base;
   logic [10:0] a_base;
   logic [10:0] p_base;
   logic [4:0]  l0_ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [10:0] r_xw_addr [8];
   logic [10:0] r_pm_addr [36];

   always #5 clk = ~clk;

   ws_inst_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .w_base         (w_base),
      .a_base         (a_base),
      .p_base         (p_base),
      .l0_ofifo_valid (l0_ofifo_valid),
      .inst           (inst),
      .busy           (busy),
      .done           (done)
   );

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [33:0] xrd(input logic [10:0] a);
      logic [33:0] v;
      v       = c_IDLE;
      v[19]   = 1'b0;
      v[17:7] = a;
      return v;
   endfunction

   function automatic logic [33:0] pwr(input logic [10:0] a);
      logic [33:0] v;
      v        = c_IDLE;
      v[32]    = 1'b0;
      v[31]    = 1'b0;
      v[30:20] = a;
      v[6]     = 1'b1;
      return v;
   endfunction

   task automatic run_tile(input logic [10:0] w, input logic [10:0] a,
                           input logic [10:0] p, input bit poke_start);
      int          cnt;
      int          nwr;
      int          wb;
      int          k;
      bit          prev;
      bit          full;
      bit          vld;
      logic [33:0] want;

      start = 1'b1; w_base = w; a_base = a; p_base = p; l0_ofifo_valid = 5'b0;
      step();
      check("busy_after_start", 34'(busy), 34'd1);
      check("inst_after_start", inst, c_IDLE);
      start = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step();
         want = xrd(11'(w + 11'(i))) | ((i > 0) ? c_L0_WR : 34'd0);
         r_xw_addr[i] = inst[17:7];
         check("w_rd", inst, want);
      end
      step();
      check("w_tail", inst, c_IDLE | c_L0_WR);

      // bases and start change while busy; the running tile must ignore them
      if (poke_start) begin
         start = 1'b1; w_base = 11'h555; a_base = 11'h2AA; p_base = 11'h123;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         check("w_load", inst, c_IDLE | c_L0_RD | c_LOAD);
      end
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("w_gap", inst, c_IDLE);
      end

      cnt = 0; nwr = 0; k = 0; prev = 1'b0;
      while (cnt < 36 && k < 100) begin
         full = (k >= 10 && k < 13);
         l0_ofifo_valid    = 5'b0;
         l0_ofifo_valid[1] = full;
         step();
         want = prev ? (c_IDLE | c_L0_WR) : c_IDLE;
         if (!full) begin
            want = xrd(11'(a + 11'(cnt))) | (prev ? c_L0_WR : 34'd0);
            cnt++;
         end
         if (inst[2]) nwr++;
         check("a_rd", inst, want);
         prev = !full;
         k++;
      end
      check("a_rd_bound", 34'(cnt), 34'd36);
      l0_ofifo_valid = 5'b0;
      step();
      if (inst[2]) nwr++;
      check("a_tail", inst, c_IDLE | c_L0_WR);
      check("l0_wr_count", 34'(nwr), 34'd36);

      for (int i = 0; i < 36; i++) begin
         step();
         check("exec", inst, c_IDLE | c_L0_RD | c_EXE);
      end

      wb = 0; k = 0;
      while (wb < 36 && k < 200) begin
         vld = (k % 2 == 0);
         l0_ofifo_valid    = 5'b0;
         l0_ofifo_valid[4] = vld;
         step();
         want = c_IDLE;
         if (vld) begin
            want = pwr(11'(p + 11'(wb)));
            r_pm_addr[wb] = inst[30:20];
            wb++;
         end
         check("wb", inst, want);
         check("wb_done", 34'(done), (wb == 36) ? 34'd1 : 34'd0);
         check("wb_busy", 34'(busy), 34'd1);
         k++;
      end
      check("wb_bound", 34'(wb), 34'd36);
      l0_ofifo_valid = 5'b0;
      step();
      check("post_inst", inst, c_IDLE);
      check("post_busy", 34'(busy), 34'd0);
      check("post_done", 34'(done), 34'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; w_base = '0; a_base = '0; p_base = '0;
      l0_ofifo_valid = 5'b0;
      #1;
      check("rst_inst", inst, c_IDLE);
      check("rst_busy", 34'(busy), 34'd0);
      check("rst_done", 34'(done), 34'd0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_hold_inst", inst, c_IDLE);
         check("idle_hold_busy", 34'(busy), 34'd0);
      end

      run_tile(11'd0, 11'd100, 11'd200, 1'b0);
      check("w_addr_first", 34'(r_xw_addr[0]), 34'd0);
      check("w_addr_last", 34'(r_xw_addr[7]), 34'd7);
      check("p_addr_first", 34'(r_pm_addr[0]), 34'd200);
      check("p_addr_last", 34'(r_pm_addr[35]), 34'd235);

      run_tile(11'd2044, 11'd100, 11'd2040, 1'b1);
      check("w_wrap_2047", 34'(r_xw_addr[3]), 34'd2047);
      check("w_wrap_0", 34'(r_xw_addr[4]), 34'd0);
      check("w_wrap_3", 34'(r_xw_addr[7]), 34'd3);
      check("p_wrap_2047", 34'(r_pm_addr[7]), 34'd2047);
      check("p_wrap_0", 34'(r_pm_addr[8]), 34'd0);
      check("p_wrap_27", 34'(r_pm_addr[35]), 34'd27);

      // Reset during EXEC: 63 steps reach the EXEC entry, 5 more are inside it
      start = 1'b1; w_base = 11'd0; a_base = 11'd100; p_base = 11'd200;
      step();
      start = 1'b0;
      for (int i = 0; i < 67; i++) step();
      check("pre_reset_exec", inst, c_IDLE | c_L0_RD | c_EXE);
      #2 reset = 1'b1;
      #1;
      check("async_rst_inst", inst, c_IDLE);
      check("async_rst_busy", 34'(busy), 34'd0);
      check("async_rst_done", 34'(done), 34'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("after_rst_inst", inst, c_IDLE);
         check("after_rst_busy", 34'(busy), 34'd0);
      end

      run_tile(11'd0, 11'd100, 11'd200, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
